// File: rtl/rx_bit_timer.sv
// Bit-timing stage for the USB receiver: sample strobe generation, edge resync and byte counting.
// Define RX_TIMER_STUFF_EN to enable bit-stuffing removal and stuff-error reporting.
module rx_bit_timer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable_timer,
  input  logic d_edge,
  input  logic d_orig,
  output logic shift_enable,
  output logic byte_received,
  output logic stuff_error
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] SAMPLE_CNT = CW'(SAMPLE_POINT);

  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          byte_received_q, byte_received_d;
  logic          stuff_error_q, stuff_error_d;
  logic          sample;
  logic          stuffed;

  assign sample = enable_timer && (clk_cnt_q == SAMPLE_CNT);

  // An edge marks the start of a bit, so the edge cycle itself counts as 0.
  always_comb begin
    clk_cnt_d = clk_cnt_q;
    if (!enable_timer)               clk_cnt_d = '0;
    else if (d_edge)                 clk_cnt_d = CW'(1);
    else if (clk_cnt_q == LAST_CNT)  clk_cnt_d = '0;
    else                             clk_cnt_d = clk_cnt_q + CW'(1);
  end

  always_comb begin
    shift_enable = sample && !stuffed;
  end

  // byte_received is set from the strobe itself so a byte completed in the
  // same cycle enable drops is still reported.
  always_comb begin
    bit_cnt_d       = bit_cnt_q;
    byte_received_d = shift_enable && (bit_cnt_q == 3'd7);
    if (!enable_timer)     bit_cnt_d = 3'd0;
    else if (shift_enable) bit_cnt_d = bit_cnt_q + 3'd1;
  end

`ifdef RX_TIMER_STUFF_EN
  logic [2:0] ones_cnt_q, ones_cnt_d;

  assign stuffed = (ones_cnt_q == 3'd6);

  always_comb begin
    ones_cnt_d    = ones_cnt_q;
    stuff_error_d = 1'b0;
    if (!enable_timer) begin
      ones_cnt_d = 3'd0;
    end else if (sample) begin
      if (stuffed) begin
        ones_cnt_d    = 3'd0;
        stuff_error_d = d_orig;
      end else if (d_orig) begin
        ones_cnt_d = ones_cnt_q + 3'd1;
      end else begin
        ones_cnt_d = 3'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) ones_cnt_q <= 3'd0;
    else        ones_cnt_q <= ones_cnt_d;
  end
`else
  logic unused_d_orig;
  assign unused_d_orig = d_orig;
  assign stuffed       = 1'b0;
  assign stuff_error_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      clk_cnt_q       <= '0;
      bit_cnt_q       <= 3'd0;
      byte_received_q <= 1'b0;
      stuff_error_q   <= 1'b0;
    end else begin
      clk_cnt_q       <= clk_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      byte_received_q <= byte_received_d;
      stuff_error_q   <= stuff_error_d;
    end
  end

  assign byte_received = byte_received_q;
  assign stuff_error   = stuff_error_q;

endmodule

// File: tb/tb_rx_bit_timer.sv
// Directed table-driven bench for rx_bit_timer (default parameters); each table row is one clock cycle.
module tb_rx_bit_timer;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic enable_timer = 1'b0;
  logic d_edge = 1'b0;
  logic d_orig = 1'b0;
  logic shift_enable, byte_received, stuff_error;

  always #5 clk = ~clk;

  rx_bit_timer dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable_timer (enable_timer),
    .d_edge       (d_edge),
    .d_orig       (d_orig),
    .shift_enable (shift_enable),
    .byte_received(byte_received),
    .stuff_error  (stuff_error)
  );

  typedef struct {
    logic en;
    logic dedge;
    logic orig;
    logic se;
    logic br;
    logic err;
  } vec_t;

  vec_t  tbl [0:255];
  int    tbl_len;
  string tbl_name;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: se/br/err got %b expected %b", name, act, exp);
    end
  endtask

  task automatic new_tbl(input string name, input int len);
    tbl_name = name;
    tbl_len  = len;
    for (int i = 0; i < len; i++)
      tbl[i] = '{en: 1'b1, dedge: 1'b0, orig: 1'b0, se: 1'b0, br: 1'b0, err: 1'b0};
  endtask

  // Entered and left #1 after a rising edge; row i covers one full cycle.
  task automatic run_tbl();
    for (int i = 0; i < tbl_len; i++) begin
      enable_timer = tbl[i].en;
      d_edge       = tbl[i].dedge;
      d_orig       = tbl[i].orig;
      @(negedge clk);
      check($sformatf("%s cyc%0d", tbl_name, i),
            {shift_enable, byte_received, stuff_error},
            {tbl[i].se, tbl[i].br, tbl[i].err});
      @(posedge clk);
      #1;
    end
    d_edge = 1'b0;
  endtask

  task automatic do_reset();
    n_rst        = 1'b0;
    enable_timer = 1'b0;
    d_edge       = 1'b0;
    d_orig       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", {shift_enable, byte_received, stuff_error}, 3'b000);
    n_rst = 1'b1;
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $finish;
  end

  initial begin
    // Free-running: samples every 8 cycles from cycle 3, bytes at 60 and 124.
    do_reset();
    new_tbl("t1_free", 126);
    for (int k = 0; k < 16; k++) tbl[3 + 8*k].se = 1'b1;
    tbl[60].br  = 1'b1;
    tbl[124].br = 1'b1;
    run_tbl();

    // Edge at cycle 13 moves the next sample to 16.
    do_reset();
    new_tbl("t2_resync", 30);
    tbl[13].dedge = 1'b1;
    tbl[3].se  = 1'b1;
    tbl[11].se = 1'b1;
    tbl[16].se = 1'b1;
    tbl[24].se = 1'b1;
    run_tbl();

    // Abort after 5 shifts, re-enable at 46: fresh byte 49..105, pulse at 106.
    do_reset();
    new_tbl("t3_abort", 110);
    for (int i = 36; i <= 45; i++) tbl[i].en = 1'b0;
    for (int k = 0; k < 5; k++) tbl[3 + 8*k].se = 1'b1;
    for (int k = 0; k < 8; k++) tbl[49 + 8*k].se = 1'b1;
    tbl[106].br = 1'b1;
    run_tbl();

    // Async reset at clk_cnt=5, bit_cnt=6 (cycle 45).
    do_reset();
    new_tbl("t4_pre", 45);
    for (int k = 0; k < 6; k++) tbl[3 + 8*k].se = 1'b1;
    run_tbl();
    n_rst = 1'b0;
    #1;
    check("t4_async_now", {shift_enable, byte_received, stuff_error}, 3'b000);
    @(posedge clk);
    #1;
    check("t4_async_held", {shift_enable, byte_received, stuff_error}, 3'b000);
    n_rst = 1'b1;
    new_tbl("t4_post", 62);
    for (int k = 0; k < 8; k++) tbl[3 + 8*k].se = 1'b1;
    tbl[60].br = 1'b1;
    run_tbl();

    // Edge coincident with the sample at 11: strobe kept, next sample at 14.
    do_reset();
    new_tbl("t5_edge_on_sample", 32);
    tbl[11].dedge = 1'b1;
    tbl[3].se  = 1'b1;
    tbl[11].se = 1'b1;
    tbl[14].se = 1'b1;
    tbl[22].se = 1'b1;
    tbl[30].se = 1'b1;
    run_tbl();

    // Enable drops right after the 8th sample: byte pulse still fires.
    do_reset();
    new_tbl("t7_en_fall", 65);
    for (int i = 60; i < 65; i++) tbl[i].en = 1'b0;
    for (int k = 0; k < 8; k++) tbl[3 + 8*k].se = 1'b1;
    tbl[60].br = 1'b1;
    run_tbl();

    // Six 1s then a 0 at the 7th sample (cycle 51).
    do_reset();
    new_tbl("t6a_stuff_ok", 70);
    for (int i = 0; i <= 43; i++) tbl[i].orig = 1'b1;
`ifdef RX_TIMER_STUFF_EN
    for (int k = 0; k < 6; k++) tbl[3 + 8*k].se = 1'b1;
    tbl[59].se = 1'b1;
    tbl[67].se = 1'b1;
    tbl[68].br = 1'b1;
`else
    for (int k = 0; k < 9; k++) tbl[3 + 8*k].se = 1'b1;
    tbl[60].br = 1'b1;
`endif
    run_tbl();

    // Six 1s then a 1 at the 7th sample: stuff error at 52.
    do_reset();
    new_tbl("t6b_stuff_err", 70);
    for (int i = 0; i <= 51; i++) tbl[i].orig = 1'b1;
`ifdef RX_TIMER_STUFF_EN
    for (int k = 0; k < 6; k++) tbl[3 + 8*k].se = 1'b1;
    tbl[59].se  = 1'b1;
    tbl[67].se  = 1'b1;
    tbl[68].br  = 1'b1;
    tbl[52].err = 1'b1;
`else
    for (int k = 0; k < 9; k++) tbl[3 + 8*k].se = 1'b1;
    tbl[60].br = 1'b1;
`endif
    run_tbl();

    summary();
    $finish;
  end

endmodule
